// File: rtl/sd_emmc_cmd_arbiter.sv
// Round-robin arbiter sharing the SD/eMMC command path between four command sources.
// Latency: req -> mux select after 1 edge, grant after 2 edges; done/timeout pulse 1 edge after release.
// Backpressure: a grant is held until cmd_finish_i or the timeout expires; sources are not interrupted.
module sd_emmc_cmd_arbiter #(
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic       sd_clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       cmd_finish_i,
    output logic [1:0] sel_mux_o,
    output logic [3:0] grant_o,
    output logic [3:0] done_o,
    output logic [3:0] timeout_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic             found;
    logic [1:0]       idx;

    // Pick the first requester after the last granted source, wrapping around.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered select, grant, pulses and busy.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_mux_o <= 2'd0;
            grant_o   <= 4'd0;
            done_o    <= 4'd0;
            timeout_o <= 4'd0;
            busy_o    <= 1'b0;
            cnt       <= '0;
            last      <= 2'd3;
        end else begin
            done_o    <= 4'd0;
            timeout_o <= 4'd0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel_mux_o <= winner;
                        busy_o    <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    // The mux register has now adopted sel_mux_o; grant only if still wanted.
                    if (req_i[sel_mux_o]) begin
                        grant_o <= 4'b0001 << sel_mux_o;
                        cnt     <= '0;
                        state   <= GRANT;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                GRANT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (cmd_finish_i) begin
                        grant_o <= 4'd0;
                        done_o  <= 4'b0001 << sel_mux_o;
                        last    <= sel_mux_o;
                        state   <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        grant_o   <= 4'd0;
                        timeout_o <= 4'b0001 << sel_mux_o;
                        last      <= sel_mux_o;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Dead cycle lets the released source drop its request.
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    grant_o <= 4'd0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_emmc_cmd_arbiter.md
Name: sd_emmc_cmd_arbiter

Overview:
Round-robin arbiter that shares the single SD/eMMC command path between four command sources (init FSM, data-transfer engine, host register interface, maintenance/status poller). It drives the select input of the registered 4:1 command mux and holds a grant to the winning source for the whole command transaction. The grant ends when the command master reports completion or a timeout expires, and a done or timeout pulse goes back to the source.

Parameters:
TIMEOUT, 65535, max sd_clk cycles in GRANT without cmd_finish_i before forced release; legal range 2..65535
CNT_W, 16, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
sd_clk  input  1  command-domain clock
rst  input  1  synchronous active-high reset
req_i  input  4  level request per source; bit n = source n; held until done_o[n] or timeout_o[n]
cmd_finish_i  input  1  one-cycle pulse from command master: command/response phase complete
sel_mux_o  output  2  select to command mux (registered)
grant_o  output  4  one-hot grant, level; source n may pulse its start_xfr only while grant_o[n]=1
done_o  output  4  one-cycle pulse to source n on normal completion
timeout_o  output  4  one-cycle pulse to source n on timeout release
busy_o  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=1 at sd_clk edge): state=IDLE; sel_mux_o=0; grant_o=0; done_o=0; timeout_o=0; busy_o=0; timeout counter=0; last-grant pointer=3, so source 0 has top priority after reset. Reset mid-transaction aborts immediately with no done/timeout pulse.
- States: IDLE, SELECT, GRANT, RELEASE.
- IDLE:
  - If req_i != 0, pick winner w = first set bit searching from (last+1) mod 4 upward with wrap.
  - Next edge: sel_mux_o<=w, go SELECT.
  - If req_i=0, stay; sel_mux_o keeps its last value.
- SELECT: one settle cycle so the mux register adopts the new select.
  - If req_i[w]=1: grant_o<=onehot(w), counter<=0, go GRANT.
  - If req_i[w]=0 (withdrawn): go IDLE; no grant, no pulse; pointer unchanged.
  - cmd_finish_i is ignored in SELECT.
- GRANT: counter increments each cycle.
  - cmd_finish_i=1: grant_o<=0, done_o[w]<=1, last<=w, go RELEASE.
  - Else if counter==TIMEOUT-1: grant_o<=0, timeout_o[w]<=1, last<=w, go RELEASE.
  - If finish and timeout fall in the same cycle, finish wins.
  - req_i changes during GRANT are ignored; the transaction is never aborted by a requester.
- RELEASE: one cycle. done_o/timeout_o return to 0 at the next edge; go IDLE. This gives one dead cycle so the released source can drop req_i before re-arbitration.
- Latency: req_i rises in IDLE at edge 0, sel_mux_o valid after edge 1, grant_o high after edge 2. cmd_finish_i at cycle k gives done_o high and grant_o low during cycle k+1. Earliest next grant is after edge k+4.
- Invariants: grant_o is one-hot or zero; sel_mux_o == index of grant_o whenever grant_o != 0; sel_mux_o never changes while grant_o != 0; at most one bit of done_o|timeout_o set, and only in RELEASE.
- Fairness: with all req_i continuously high, grants rotate 0,1,2,3,0,...

Test Plan:
- Reset, then req_i=4'b0100 -> sel_mux_o=2 after edge 1; grant_o=4'b0100 after edge 2; cmd_finish_i pulsed 5 cycles later -> done_o=4'b0100 for exactly 1 cycle, grant_o=0, busy_o=0 two cycles after finish.
- req_i=4'b1111, each source drops req on its done -> grant order 0,1,2,3; sel_mux_o stable during each grant; 3 idle-to-grant overhead cycles between transactions.
- TIMEOUT=8, req_i=4'b0010, no cmd_finish_i -> timeout_o=4'b0010 pulse 8 cycles after grant rises; done_o stays 0; next arbitration starts from source 2.
- cmd_finish_i in the same cycle counter==TIMEOUT-1 -> done_o pulses, timeout_o stays 0.
- req_i[1] raised then dropped during SELECT -> no grant, return to IDLE; later req_i=4'b0001 is granted normally. Also cmd_finish_i pulsed in IDLE/SELECT -> no effect.
- rst asserted while grant_o=4'b1000 -> all outputs 0 next edge, no pulse; the next req_i=4'b1001 grants source 0 first.
